// File: rtl/fetch_pkg.sv
// Shared BTB entry layout, 2-bit counter encodings and the counter update helper
// used by the fetch stage and its branch target buffer.
package fetch_pkg;

  // Storage width of tag/target fields; the fetch stage's XLEN must not exceed it.
  localparam int ENTRY_W = 32;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef struct packed {
    logic               valid;
    logic [ENTRY_W-1:0] tag;
    logic [ENTRY_W-1:0] target;
    logic [1:0]         ctr;
  } btb_entry_t;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == ST) ? ST : ctr + 2'd1;
    else       return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/btb.sv
// Direct-mapped branch target buffer: one combinational lookup port and one
// registered update port; a same-cycle update is only seen by the next lookup.
module btb
  import fetch_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BTB_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:2] lookup_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_vld,
  input  logic [XLEN-1:2] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken
);

  localparam int IDX = $clog2(BTB_DEPTH);

  btb_entry_t mem [BTB_DEPTH];

  logic [IDX-1:0]     l_idx;
  logic [IDX-1:0]     u_idx;
  logic [ENTRY_W-1:0] l_tag;
  logic [ENTRY_W-1:0] u_tag;
  logic               l_hit;
  logic               u_hit;

  assign l_idx = lookup_pc[IDX+1:2];
  assign u_idx = upd_pc[IDX+1:2];
  assign l_tag = ENTRY_W'(lookup_pc[XLEN-1:IDX+2]);
  assign u_tag = ENTRY_W'(upd_pc[XLEN-1:IDX+2]);

  assign l_hit       = mem[l_idx].valid && (mem[l_idx].tag == l_tag);
  assign u_hit       = mem[u_idx].valid && (mem[u_idx].tag == u_tag);
  assign pred_taken  = l_hit && mem[l_idx].ctr[1];
  assign pred_target = pred_taken ? mem[l_idx].target[XLEN-1:0] : '0;

  // Tag/target are left unreset; valid=0 makes their contents irrelevant.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        mem[i].valid <= 1'b0;
        mem[i].ctr   <= WNT;
      end
    end else if (upd_vld) begin
      if (u_hit) begin
        mem[u_idx].ctr <= ctr_next(mem[u_idx].ctr, upd_taken);
        if (upd_taken) mem[u_idx].target <= ENTRY_W'(upd_target);
      end else if (upd_taken) begin
        mem[u_idx] <= '{valid: 1'b1, tag: u_tag, target: ENTRY_W'(upd_target), ctr: WT};
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch PC register with next-PC selection (reset, redirect, stall,
// BTB prediction, sequential) and the BTB that feeds the prediction.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              BTB_DEPTH = 16,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_stall,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  input  logic            i_upd_vld,
  input  logic [XLEN-1:0] i_upd_pc,
  input  logic [XLEN-1:0] i_upd_target,
  input  logic            i_upd_taken,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_4,
  output logic            o_pred_taken,
  output logic [XLEN-1:0] o_pred_target,
  output logic            o_vld
);

  logic [XLEN-1:0] pc_p0;
  logic            vld_p0;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] seq_pc;

  // Low address bits are word-alignment only and never steer anything.
  logic unused_low_bits;
  assign unused_low_bits = &{1'b0, i_redirect_pc[1:0], i_upd_pc[1:0]};

  btb #(
    .XLEN      (XLEN),
    .BTB_DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk         (i_clk),
    .rst         (i_rst),
    .lookup_pc   (pc_p0[XLEN-1:2]),
    .pred_taken  (o_pred_taken),
    .pred_target (o_pred_target),
    .upd_vld     (i_upd_vld),
    .upd_pc      (i_upd_pc[XLEN-1:2]),
    .upd_target  (i_upd_target),
    .upd_taken   (i_upd_taken)
  );

  assign seq_pc = pc_p0 + XLEN'(4);

  always_comb begin
    pc_next = seq_pc;
    if (i_redirect)        pc_next = {i_redirect_pc[XLEN-1:2], 2'b00};
    else if (i_stall)      pc_next = pc_p0;
    else if (o_pred_taken) pc_next = o_pred_target;
  end

  // Stage p0: registered fetch address
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_p0  <= RESET_PC;
      vld_p0 <= 1'b0;
    end else begin
      pc_p0  <= pc_next;
      vld_p0 <= 1'b1;
    end
  end

  assign o_pc   = pc_p0;
  assign o_pc_4 = seq_pc;
  assign o_vld  = vld_p0;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, BTB allocation, counter hysteresis,
// next-PC priority, same-index aliasing, PC wrap and reset discarding updates.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        upd_vld;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic [31:0] pc;
  logic [31:0] pc_4;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        vld;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_stage #(
    .XLEN      (32),
    .BTB_DEPTH (16),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_stall       (stall),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .i_upd_vld     (upd_vld),
    .i_upd_pc      (upd_pc),
    .i_upd_target  (upd_target),
    .i_upd_taken   (upd_taken),
    .o_pc          (pc),
    .o_pc_4        (pc_4),
    .o_pred_taken  (pred_taken),
    .o_pred_target (pred_target),
    .o_vld         (vld)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic upd(input logic v, input logic [31:0] p, input logic [31:0] t, input logic tk);
    upd_vld    = v;
    upd_pc     = p;
    upd_target = t;
    upd_taken  = tk;
  endtask

  task automatic redir(input logic r, input logic [31:0] p);
    redirect    = r;
    redirect_pc = p;
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    redir(1'b0, 32'h0);
    upd(1'b0, 32'h0, 32'h0, 1'b0);

    // reset held for two cycles
    tick();
    tick();
    check("rst_pc", pc, 32'h0);
    check("rst_vld", {31'b0, vld}, 32'h0);
    check("rst_pred", {31'b0, pred_taken}, 32'h0);
    check("rst_pred_tgt", pred_target, 32'h0);
    check("rst_pc4", pc_4, 32'h4);

    rst = 1'b0;
    tick();
    check("seq_pc4", pc, 32'h4);
    check("seq_vld", {31'b0, vld}, 32'h1);
    check("seq_pred", {31'b0, pred_taken}, 32'h0);
    // allocate 0x10 -> 0x40 while fetching 0x8
    upd(1'b1, 32'h10, 32'h40, 1'b1);
    tick();
    check("seq_pc8", pc, 32'h8);
    upd(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    check("seq_pcC", pc, 32'hC);
    tick();
    check("alloc_pc", pc, 32'h10);
    check("alloc_pred", {31'b0, pred_taken}, 32'h1);
    check("alloc_tgt", pred_target, 32'h40);
    tick();
    check("alloc_follow", pc, 32'h40);
    check("alloc_pc4", pc_4, 32'h44);

    // hysteresis: 10 -NT-> 01 (off)
    upd(1'b1, 32'h10, 32'h99C, 1'b0);
    redir(1'b1, 32'h10);
    tick();
    check("hys_redir_pc", pc, 32'h10);
    check("hys_nt_pred", {31'b0, pred_taken}, 32'h0);
    check("hys_nt_tgt", pred_target, 32'h0);
    // 01 -T-> 10 with stall holding the PC, target rewritten to 0x60
    redir(1'b0, 32'h0);
    stall = 1'b1;
    upd(1'b1, 32'h10, 32'h60, 1'b1);
    tick();
    check("hys_stall_pc", pc, 32'h10);
    check("hys_t1_pred", {31'b0, pred_taken}, 32'h1);
    check("hys_t1_tgt", pred_target, 32'h60);
    tick();
    check("hys_t2_pred", {31'b0, pred_taken}, 32'h1);
    tick();
    check("hys_t3_pred", {31'b0, pred_taken}, 32'h1);
    // saturated at 11: one NT keeps it on, the second turns it off
    upd(1'b1, 32'h10, 32'h0, 1'b0);
    tick();
    check("hys_sat_nt1", {31'b0, pred_taken}, 32'h1);
    check("hys_nt_keeps_tgt", pred_target, 32'h60);
    tick();
    check("hys_sat_nt2", {31'b0, pred_taken}, 32'h0);
    check("hys_still_stall", pc, 32'h10);

    // priority: redirect beats stall and alignment is forced
    upd(1'b0, 32'h0, 32'h0, 1'b0);
    redir(1'b1, 32'h103);
    tick();
    check("prio_redir", pc, 32'h100);
    redir(1'b0, 32'h0);
    tick();
    check("prio_stall1", pc, 32'h100);
    tick();
    check("prio_stall2", pc, 32'h100);

    // aliasing: make 0x10 predict 0x70, then replace it with 0x50 while fetching 0x10
    stall = 1'b0;
    upd(1'b1, 32'h10, 32'h70, 1'b1);
    redir(1'b1, 32'h10);
    tick();
    redir(1'b0, 32'h0);
    upd(1'b1, 32'h50, 32'h90, 1'b1);
    check("alias_old_pred", {31'b0, pred_taken}, 32'h1);
    check("alias_old_tgt", pred_target, 32'h70);
    tick();
    upd(1'b0, 32'h0, 32'h0, 1'b0);
    check("alias_follow", pc, 32'h70);
    redir(1'b1, 32'h10);
    tick();
    redir(1'b0, 32'h0);
    check("alias_miss_pred", {31'b0, pred_taken}, 32'h0);
    tick();
    check("alias_miss_seq", pc, 32'h14);
    redir(1'b1, 32'h50);
    tick();
    redir(1'b0, 32'h0);
    check("alias_new_pred", {31'b0, pred_taken}, 32'h1);
    check("alias_new_tgt", pred_target, 32'h90);

    // wrap at the top of the address space
    redir(1'b1, 32'hFFFF_FFFC);
    tick();
    redir(1'b0, 32'h0);
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    check("wrap_pc4", pc_4, 32'h0);
    tick();
    check("wrap_next", pc, 32'h0);

    // reset overrides stall/redirect and discards a concurrent update
    rst = 1'b1;
    stall = 1'b1;
    redir(1'b1, 32'h500);
    upd(1'b1, 32'h20, 32'h200, 1'b1);
    tick();
    check("rst2_pc", pc, 32'h0);
    check("rst2_vld", {31'b0, vld}, 32'h0);
    check("rst2_pred", {31'b0, pred_taken}, 32'h0);
    rst = 1'b0;
    stall = 1'b0;
    upd(1'b0, 32'h0, 32'h0, 1'b0);
    redir(1'b1, 32'h20);
    tick();
    check("rst2_vld_after", {31'b0, vld}, 32'h1);
    check("rst2_discard", {31'b0, pred_taken}, 32'h0);
    redir(1'b1, 32'h50);
    tick();
    redir(1'b0, 32'h0);
    check("rst2_cleared", {31'b0, pred_taken}, 32'h0);
    check("rst2_cleared_tgt", pred_target, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
